// File: rtl/sram_init_bridge_if.sv
// CPU-side memory bus of the SRAM init bridge: address, active-low strobes,
// write data out to memory and registered read data back to the CPU.
interface sram_init_bridge_if;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;

  modport master (
    output ADDR, OE, WE, Data_to_SRAM,
    input  Data_from_SRAM
  );

  modport slave (
    input  ADDR, OE, WE, Data_to_SRAM,
    output Data_from_SRAM
  );
endinterface

// File: rtl/sram_init_bridge.sv
// SRAM init bridge: after reset, copies INIT_WORDS words from a synchronous
// program ROM into a synchronous RAM while holding the CPU, then hands the RAM
// over to the CPU bus. Addresses at or above IO_BASE are left to the I/O path.
module sram_init_bridge #(
  parameter int          AW         = 10,
  parameter int          INIT_WORDS = 256,
  parameter logic [15:0] IO_BASE    = 16'hFE00
) (
  input  logic                Clk,
  input  logic                Reset,
  sram_init_bridge_if.slave   cpu,
  output logic                Cpu_Hold,
  output logic                Init_Done,
  output logic [AW-1:0]       rom_addr,
  input  logic [15:0]         rom_data,
  output logic [AW-1:0]       ram_addr,
  output logic [15:0]         ram_wdata,
  output logic                ram_we,
  input  logic [15:0]         ram_rdata
);

  typedef enum logic [1:0] {S_INIT, S_FLUSH, S_RUN} state_t;

  // One extra counter bit so INIT_WORDS == 2^AW does not wrap the copy count.
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  LAST = CW'(INIT_WORDS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_wr_pend;   // a ROM address went out last cycle; its data is here now
  logic            r_rd_pend;   // RAM read issued last edge; capture ram_rdata next edge
  logic [15:0]     r_dout;

  logic            w_in_mem;
  logic            w_cpu_wr;
  logic            w_cpu_rd;
  logic [AW-1:0]   w_cnt_m1;

  assign w_in_mem = (cpu.ADDR < IO_BASE);
  assign w_cpu_wr = !cpu.WE && w_in_mem;
  // A simultaneous OE/WE is treated as a write only.
  assign w_cpu_rd = !cpu.OE && cpu.WE && w_in_mem;
  assign w_cnt_m1 = r_cnt[AW-1:0] - AW'(1);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // Next-state: copy, one flush cycle for the last ROM word, then RUN forever.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (r_cnt == LAST) w_next = S_FLUSH;
      S_FLUSH: w_next = S_RUN;
      S_RUN:   w_next = S_RUN;
      default: w_next = S_INIT;
    endcase
  end

  // Copy counter, pending flags and the registered CPU read data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_dout    <= 16'h0000;
    end else begin
      r_wr_pend <= (r_state == S_INIT);
      if (r_state == S_INIT) r_cnt <= r_cnt + CW'(1);
      r_rd_pend <= (r_state == S_RUN) && w_cpu_rd;
      if (r_rd_pend) r_dout <= ram_rdata;
    end
  end

  // Outputs: ROM->RAM copy trails the ROM address by one cycle; in RUN the
  // CPU bus drives the RAM directly with the address aliased to AW bits.
  always_comb begin
    rom_addr  = '0;
    ram_addr  = '0;
    ram_wdata = 16'h0000;
    ram_we    = 1'b0;
    Init_Done = 1'b0;
    case (r_state)
      S_INIT: begin
        rom_addr  = r_cnt[AW-1:0];
        ram_addr  = w_cnt_m1;
        ram_wdata = rom_data;
        ram_we    = r_wr_pend;
      end
      S_FLUSH: begin
        ram_addr  = w_cnt_m1;
        ram_wdata = rom_data;
        ram_we    = r_wr_pend;
      end
      S_RUN: begin
        ram_addr  = cpu.ADDR[AW-1:0];
        ram_wdata = cpu.Data_to_SRAM;
        ram_we    = w_cpu_wr;
        Init_Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign Cpu_Hold           = !Init_Done;
  assign cpu.Data_from_SRAM = r_dout;

endmodule

// File: tb/tb_sram_init_bridge.sv
// Directed bench for sram_init_bridge with behavioural synchronous ROM/RAM.
module tb_sram_init_bridge;
  localparam int AW = 10;
  localparam int IW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Cpu_Hold, Init_Done;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [15:0]   rom_data, ram_wdata, ram_rdata;
  logic          ram_we;

  sram_init_bridge_if cpu();

  sram_init_bridge #(.AW(AW), .INIT_WORDS(IW), .IO_BASE(16'hFE00)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu       (cpu),
    .Cpu_Hold  (Cpu_Hold),
    .Init_Done (Init_Done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 Clk = ~Clk;

  logic [15:0] rom [0:1023];
  logic [15:0] ram [0:1023];

  always @(posedge Clk) begin
    rom_data  <= rom[rom_addr];
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_idle;
    cpu.ADDR = 16'h0000; cpu.OE = 1'b1; cpu.WE = 1'b1; cpu.Data_to_SRAM = 16'h0000;
  endtask

  typedef struct {
    logic          chk_rom;
    logic [AW-1:0] rom_a;
    logic          we;
    logic [AW-1:0] ram_a;
    logic [15:0]   wd;
    logic          done;
  } init_v_t;

  typedef struct {
    logic [15:0]   addr;
    logic          oe;
    logic          we;
    logic [15:0]   wd;
    logic          exp_we;
    logic [AW-1:0] exp_ra;
    logic [15:0]   exp_dout;
  } run_v_t;

  init_v_t iv[6];
  run_v_t  rv[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // state after release, then after each edge 1..5
    iv[0] = '{1'b1, 10'd0, 1'b0, 10'd0, 16'h0000, 1'b0};
    iv[1] = '{1'b1, 10'd1, 1'b1, 10'd0, 16'h1111, 1'b0};
    iv[2] = '{1'b1, 10'd2, 1'b1, 10'd1, 16'h2222, 1'b0};
    iv[3] = '{1'b1, 10'd3, 1'b1, 10'd2, 16'h3333, 1'b0};
    iv[4] = '{1'b0, 10'd0, 1'b1, 10'd3, 16'h4444, 1'b0};
    iv[5] = '{1'b1, 10'd0, 1'b0, 10'd0, 16'h0000, 1'b1};

    //         addr      oe    we    wdata     we?   ram_addr  dout after
    rv[0]  = '{16'h0002, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h002, 16'h3333};
    rv[1]  = '{16'h0010, 1'b1, 1'b0, 16'hABCD, 1'b1, 10'h010, 16'h3333};
    rv[2]  = '{16'h0010, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h010, 16'hABCD};
    rv[3]  = '{16'h0004, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h004, 16'hA004};
    rv[4]  = '{16'hFFFF, 1'b1, 1'b0, 16'h1234, 1'b0, 10'h3FF, 16'hA004};
    rv[5]  = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h3FF, 16'hA004};
    rv[6]  = '{16'h0410, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h010, 16'hABCD};
    rv[7]  = '{16'h0005, 1'b0, 1'b0, 16'h5555, 1'b1, 10'h005, 16'hABCD};
    rv[8]  = '{16'h0005, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h005, 16'h5555};
    rv[9]  = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h000, 16'h1111};
    rv[10] = '{16'h0410, 1'b1, 1'b0, 16'h7777, 1'b1, 10'h010, 16'h1111};
    rv[11] = '{16'h0010, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h010, 16'h7777};
    rv[12] = '{16'hFE00, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h200, 16'h7777};
    rv[13] = '{16'hFDFF, 1'b1, 1'b0, 16'h4242, 1'b1, 10'h1FF, 16'h7777};
    rv[14] = '{16'hFDFF, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h1FF, 16'h4242};
    rv[15] = '{16'h0003, 1'b0, 1'b1, 16'h0000, 1'b0, 10'h003, 16'h4444};

    for (int i = 0; i < 1024; i++) begin
      rom[i] = 16'hC000 | 16'(i);
      ram[i] = 16'hA000 | 16'(i);
    end
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;

    Reset = 1'b1;
    cpu_idle();
    tick();
    tick();
    chk("rst_done",  {31'd0, Init_Done}, 32'd0);
    chk("rst_hold",  {31'd0, Cpu_Hold},  32'd1);
    chk("rst_we",    {31'd0, ram_we},    32'd0);
    chk("rst_dout",  {16'd0, cpu.Data_from_SRAM}, 32'h0);
    chk("rst_rom_a", {22'd0, rom_addr},  32'd0);

    // release; CPU hammers a write during copy, which must be ignored
    Reset = 1'b0;
    cpu.ADDR = 16'h0100; cpu.OE = 1'b0; cpu.WE = 1'b0; cpu.Data_to_SRAM = 16'hBEEF;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) cpu_idle();
      if (k > 0) tick();
      #1;
      if (iv[k].chk_rom) chk($sformatf("init%0d_rom_a", k), {22'd0, rom_addr}, {22'd0, iv[k].rom_a});
      chk($sformatf("init%0d_we", k), {31'd0, ram_we}, {31'd0, iv[k].we});
      if (iv[k].we) begin
        chk($sformatf("init%0d_ram_a", k), {22'd0, ram_addr}, {22'd0, iv[k].ram_a});
        chk($sformatf("init%0d_wd", k), {16'd0, ram_wdata}, {16'd0, iv[k].wd});
      end
      chk($sformatf("init%0d_done", k), {31'd0, Init_Done}, {31'd0, iv[k].done});
      chk($sformatf("init%0d_hold", k), {31'd0, Cpu_Hold}, {31'd0, !iv[k].done});
    end
    chk("ram0", {16'd0, ram[0]}, 32'h1111);
    chk("ram1", {16'd0, ram[1]}, 32'h2222);
    chk("ram2", {16'd0, ram[2]}, 32'h3333);
    chk("ram3", {16'd0, ram[3]}, 32'h4444);
    chk("ram4_untouched", {16'd0, ram[4]}, 32'hA004);
    chk("ram100_ignored", {16'd0, ram[10'h100]}, 32'hA100);

    // RUN vectors: each access one cycle, then idle, dout checked two edges on
    for (int i = 0; i < 16; i++) begin
      cpu.ADDR = rv[i].addr; cpu.OE = rv[i].oe; cpu.WE = rv[i].we; cpu.Data_to_SRAM = rv[i].wd;
      #1;
      chk($sformatf("v%0d_we", i), {31'd0, ram_we}, {31'd0, rv[i].exp_we});
      chk($sformatf("v%0d_ram_a", i), {22'd0, ram_addr}, {22'd0, rv[i].exp_ra});
      chk($sformatf("v%0d_wd", i), {16'd0, ram_wdata}, {16'd0, rv[i].wd});
      chk($sformatf("v%0d_rom_a", i), {22'd0, rom_addr}, 32'd0);
      tick();
      cpu_idle();
      tick();
      tick();
      chk($sformatf("v%0d_dout", i), {16'd0, cpu.Data_from_SRAM}, {16'd0, rv[i].exp_dout});
    end
    chk("ram3ff_io_nowrite", {16'd0, ram[10'h3FF]}, 32'hA3FF);

    // exact latency: capture on the edge after the sampling edge, OE dropped
    cpu.ADDR = 16'h0001; cpu.OE = 1'b0; cpu.WE = 1'b1;
    tick();
    cpu_idle();
    chk("lat_edge_n", {16'd0, cpu.Data_from_SRAM}, 32'h4444);
    tick();
    chk("lat_edge_n1", {16'd0, cpu.Data_from_SRAM}, 32'h2222);

    // back-to-back reads pipeline one per cycle
    cpu.ADDR = 16'h0000; cpu.OE = 1'b0;
    tick();
    cpu.ADDR = 16'h0002;
    tick();
    cpu_idle();
    chk("b2b_first", {16'd0, cpu.Data_from_SRAM}, 32'h1111);
    tick();
    chk("b2b_second", {16'd0, cpu.Data_from_SRAM}, 32'h3333);

    // reset mid-RUN with a read pending and a write being driven
    cpu.ADDR = 16'h0003; cpu.OE = 1'b0; cpu.WE = 1'b1;
    tick();
    cpu.WE = 1'b0; cpu.OE = 1'b1; cpu.ADDR = 16'h0000; cpu.Data_to_SRAM = 16'h9999;
    Reset = 1'b1;
    #1;
    chk("mrst_dout", {16'd0, cpu.Data_from_SRAM}, 32'h0);
    chk("mrst_done", {31'd0, Init_Done}, 32'd0);
    chk("mrst_hold", {31'd0, Cpu_Hold}, 32'd1);
    chk("mrst_we",   {31'd0, ram_we}, 32'd0);
    tick();
    chk("mrst_dout_held", {16'd0, cpu.Data_from_SRAM}, 32'h0);
    cpu_idle();
    Reset = 1'b0;

    // reset pulse on the third INIT edge
    tick();
    tick();
    tick();
    chk("pre_irst_rom_a", {22'd0, rom_addr}, 32'd3);
    Reset = 1'b1;
    #1;
    chk("irst_rom_a", {22'd0, rom_addr}, 32'd0);
    chk("irst_we",    {31'd0, ram_we}, 32'd0);
    chk("irst_hold",  {31'd0, Cpu_Hold}, 32'd1);
    tick();
    Reset = 1'b0;
    #1;
    chk("irel_rom_a", {22'd0, rom_addr}, 32'd0);
    begin
      int n;
      n = 0;
      while (!Init_Done && n < 50) begin
        tick();
        n++;
      end
      chk("irel_edges_to_done", 32'(n), 32'(IW + 1));
    end
    chk("irel_ram0", {16'd0, ram[0]}, 32'h1111);
    chk("irel_ram3", {16'd0, ram[3]}, 32'h4444);
    chk("irel_ram0_not_9999", {16'd0, ram[0]}, 32'h1111);
    chk("irel_dout", {16'd0, cpu.Data_from_SRAM}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_init_bridge.md
SRAM_INIT_BRIDGE -- requirements
Module: sram_init_bridge

Interface
REQ-001 SHALL have parameter AW, default 10, RAM word-address width (2^AW x 16-bit words).
REQ-002 SHALL have parameter INIT_WORDS, default 256, number of words copied from ROM to RAM after reset (1..2^AW).
REQ-003 SHALL have parameter IO_BASE, default 16'hFE00, first 16-bit address of the memory-mapped I/O region.
REQ-004 SHALL use one clock; reset is asynchronous and active-high, with ports named Clk and Reset.
REQ-005 Clk  in  1  system clock; all state updates on rising edge.
REQ-006 Reset  in  1  asynchronous active-high reset.
REQ-007 ADDR  in  16  CPU address (MAR).
REQ-008 OE  in  1  CPU read enable, active-low.
REQ-009 WE  in  1  CPU write enable, active-low.
REQ-010 Data_to_SRAM  in  16  CPU write data.
REQ-011 Data_from_SRAM  out  16  registered read data to CPU.
REQ-012 Cpu_Hold  out  1  high while initialisation runs; CPU held in reset.
REQ-013 Init_Done  out  1  high once initialisation completes.
REQ-014 rom_addr  out  AW  program ROM address; synchronous ROM, 1-cycle read latency.
REQ-015 rom_data  in  16  ROM read data.
REQ-016 ram_addr  out  AW  RAM address.
REQ-017 ram_wdata  out  16  RAM write data.
REQ-018 ram_we  out  1  RAM write strobe, active-high, sampled on Clk edge.
REQ-019 ram_rdata  in  16  RAM read data; synchronous RAM, 1-cycle read latency.

Function
REQ-020 SHALL implement states INIT, FLUSH and RUN; Reset forces INIT.
REQ-021 INIT: counter cnt starts at 0; each cycle rom_addr = cnt and cnt increments.
REQ-022 Each ROM word SHALL be written one cycle after its address is issued: ram_we=1, ram_addr=cnt-1, ram_wdata=rom_data; no write in the first INIT cycle.
REQ-023 INIT -> FLUSH on the edge where cnt = INIT_WORDS-1; FLUSH writes word INIT_WORDS-1, then -> RUN on the next edge.
REQ-024 RAM word k SHALL equal ROM word k for k < INIT_WORDS; words >= INIT_WORDS are untouched.
REQ-025 Init_Done SHALL be high exactly in RUN, i.e. after INIT_WORDS+1 edges following Reset release; Cpu_Hold = !Init_Done.
REQ-026 During INIT and FLUSH, ADDR, OE, WE and Data_to_SRAM SHALL be ignored.
REQ-027 RUN: ram_addr = ADDR[AW-1:0], aliasing higher bits; ram_wdata = Data_to_SRAM; rom_addr = 0.
REQ-028 RUN: ram_we = 1 iff WE=0 and ADDR < IO_BASE.
REQ-029 RUN read: if OE=0, WE=1 and ADDR < IO_BASE at edge n, Data_from_SRAM SHALL be loaded with ram_rdata at edge n+1; 2-cycle address-to-output latency.
REQ-030 Data_from_SRAM SHALL hold its value in all other cycles.
REQ-031 OE=0 and WE=0 together: the write SHALL occur and no read capture SHALL be scheduled.
REQ-032 ADDR >= IO_BASE: no RAM write and no read capture; Mem2IO serves the access.
REQ-033 A read pending at edge n SHALL complete at n+1 even if OE deasserts.
REQ-034 RUN SHALL be terminal until Reset.

Reset
REQ-035 Reset asserted SHALL immediately force state=INIT, cnt=0, pending write and read flags=0, Data_from_SRAM=16'h0000, Init_Done=0, Cpu_Hold=1, ram_we=0.
REQ-036 Reset mid-INIT or mid-RUN SHALL restart the copy from word 0 after release; pending operations are discarded.

Verification
REQ-037 INIT_WORDS=4, ROM={1111,2222,3333,4444} -> writes RAM[0..3] with these values on edges 2..5; Init_Done rises after edge 5; Cpu_Hold falls together.
REQ-038 RUN: ADDR=0002, OE=0 at edge n -> Data_from_SRAM=3333 after edge n+2; unchanged after OE returns high.
REQ-039 RUN: ADDR=0010, WE=0, Data_to_SRAM=ABCD -> ram_we=1, ram_addr=010; a later read of 0010 returns ABCD. With AW=10, ADDR=0410 aliases to RAM[010].
REQ-040 RUN: ADDR=FFFF, WE=0 then OE=0 -> ram_we stays 0; Data_from_SRAM unchanged.
REQ-041 OE=0 and WE=0 at ADDR=0005, data=5555 -> RAM[5]=5555; Data_from_SRAM not updated.
REQ-042 Reset pulse on the third INIT edge -> outputs return to reset values at once; the copy restarts at rom_addr=0 and Init_Done rises INIT_WORDS+1 edges after release.
